// File: rtl/cnt_snapshot_fifo.sv
// rtl/cnt_snapshot_fifo.sv - counter/carry-sum snapshot capture into a small FIFO
module cnt_snapshot_fifo #(
    parameter int CNT_W     = 8,
    parameter int CC_W      = 2,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int TRIG_EDGE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        cnt_in,
    input  logic [CC_W-1:0]         cc_in,
    input  logic                    trig,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [CNT_W+CC_W-1:0]   out_data,
    output logic [ADDR_W:0]         level,
    output logic                    full,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    input  logic                    clr_ovf
);

    localparam int DW = CNT_W + CC_W;

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              trig_q;
    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;

    // trig_q resets low so a trigger held across reset release yields one capture
    assign cap       = (TRIG_EDGE != 0) ? (trig & ~trig_q) : trig;
    assign out_valid = (level != '0);
    assign full      = (level == (ADDR_W + 1)'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {cc_in, cnt_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf restarts the count at one
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_cnt_snapshot_fifo.sv
// tb/tb_cnt_snapshot_fifo.sv - scoreboard bench for cnt_snapshot_fifo (edge and level trigger)
module tb_cnt_snapshot_fifo;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_ovf;
    logic [7:0]       cnt_in;
    logic [1:0]       cc_in;
    logic [1:0]       trig;
    logic [1:0]       rdy;
    logic [1:0]       vld;
    logic [1:0]       fl;
    logic [1:0]       ovf;
    logic [1:0][9:0]  od;
    logic [1:0][2:0]  lvl;
    logic [1:0][7:0]  dc;

    int total = 0;
    int bad   = 0;

    // model state: instance 0 edge-triggered, instance 1 level-triggered
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    bit         tq0, tq1;
    bit         movf0, movf1;
    int         mdc0, mdc1;
    int         pops1;

    always #5 clk = ~clk;

    cnt_snapshot_fifo #(.TRIG_EDGE(1)) dut_e (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cc_in(cc_in), .trig(trig[0]),
        .out_ready(rdy[0]), .out_valid(vld[0]), .out_data(od[0]), .level(lvl[0]),
        .full(fl[0]), .overflow(ovf[0]), .drop_cnt(dc[0]), .clr_ovf(clr_ovf)
    );

    cnt_snapshot_fifo #(.TRIG_EDGE(0)) dut_l (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cc_in(cc_in), .trig(trig[1]),
        .out_ready(rdy[1]), .out_valid(vld[1]), .out_data(od[1]), .level(lvl[1]),
        .full(fl[1]), .overflow(ovf[1]), .drop_cnt(dc[1]), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // advance one clock: update the model from pre-edge inputs, then compare after the edge
    task automatic step();
        bit cap, pop, push, drop, full;
        logic [9:0] d;
        // instance 0
        full = (q0.size() == 4);
        cap  = trig[0] & !tq0;
        pop  = (q0.size() != 0) & rdy[0];
        if (rst) begin
            q0.delete(); movf0 = 0; mdc0 = 0; tq0 = 0;
        end else begin
            if (pop) begin
                d = q0.pop_front();
                chk("e_pop_data", od[0], d);
            end
            push = cap & (!full | pop);
            drop = cap & full & !pop;
            if (push) q0.push_back({cc_in, cnt_in});
            if (drop) begin
                movf0 = 1; mdc0 = clr_ovf ? 1 : sat_inc(mdc0);
            end else if (clr_ovf) begin
                movf0 = 0; mdc0 = 0;
            end
            tq0 = trig[0];
        end
        // instance 1
        full = (q1.size() == 4);
        cap  = trig[1];
        pop  = (q1.size() != 0) & rdy[1];
        if (rst) begin
            q1.delete(); movf1 = 0; mdc1 = 0; tq1 = 0;
        end else begin
            if (pop) begin
                d = q1.pop_front();
                chk("l_pop_data", od[1], d);
                pops1++;
            end
            push = cap & (!full | pop);
            drop = cap & full & !pop;
            if (push) q1.push_back({cc_in, cnt_in});
            if (drop) begin
                movf1 = 1; mdc1 = clr_ovf ? 1 : sat_inc(mdc1);
            end else if (clr_ovf) begin
                movf1 = 0; mdc1 = 0;
            end
            tq1 = trig[1];
        end
        @(posedge clk);
        #1;
        chk("e_valid", vld[0], q0.size() != 0);
        chk("e_data",  od[0],  (q0.size() != 0) ? q0[0] : 10'd0);
        chk("e_level", lvl[0], q0.size());
        chk("e_full",  fl[0],  q0.size() == 4);
        chk("e_ovf",   ovf[0], movf0);
        chk("e_dcnt",  dc[0],  mdc0);
        chk("l_valid", vld[1], q1.size() != 0);
        chk("l_data",  od[1],  (q1.size() != 0) ? q1[0] : 10'd0);
        chk("l_level", lvl[1], q1.size());
        chk("l_ovf",   ovf[1], movf1);
        chk("l_dcnt",  dc[1],  mdc1);
    endtask

    task automatic pulse(input logic [7:0] c, input logic [1:0] s);
        cnt_in = c; cc_in = s; trig[0] = 1'b1;
        step();
        trig[0] = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; clr_ovf = 1'b0; cnt_in = 8'h33; cc_in = 2'd1;
        trig = 2'b01; rdy = 2'b00; pops1 = 0;
        tq0 = 0; tq1 = 0; movf0 = 0; movf1 = 0; mdc0 = 0; mdc1 = 0;

        // 1: reset with trig high, release -> one capture
        repeat (3) step();
        chk("rst_level", lvl[0], 0);
        chk("rst_data",  od[0],  0);
        rst = 1'b0;
        repeat (4) step();
        chk("t1_one_capture", lvl[0], 1);
        chk("t1_data", od[0], 10'h133);
        trig[0] = 1'b0; rdy[0] = 1'b1;
        step();
        rdy[0] = 1'b0;

        // 2: single capture, consumer stalled
        pulse(8'd5, 2'd2);
        chk("t2_valid", vld[0], 1);
        chk("t2_data",  od[0],  10'h205);
        chk("t2_level", lvl[0], 1);
        rdy[0] = 1'b1; step(); rdy[0] = 1'b0;

        // 3: fill, overflow by one, drain in order
        for (int i = 1; i <= 4; i++) pulse(8'(i), 2'd0);
        pulse(8'd99, 2'd3);
        chk("t3_full", fl[0], 1);
        chk("t3_ovf",  ovf[0], 1);
        chk("t3_dcnt", dc[0], 1);
        chk("t3_head", od[0], 10'h001);
        rdy[0] = 1'b1;
        repeat (5) step();
        chk("t3_empty", vld[0], 0);
        rdy[0] = 1'b0;

        // 4: full, capture and pop together
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        for (int i = 10; i <= 13; i++) pulse(8'(i), 2'd1);
        rdy[0] = 1'b1; cnt_in = 8'd14; trig[0] = 1'b1;
        step();
        rdy[0] = 1'b0; trig[0] = 1'b0;
        chk("t4_level", lvl[0], 4);
        chk("t4_head",  od[0],  10'h10B);
        chk("t4_nodrop", ovf[0], 0);
        step();

        // 5: saturate drop counter, then clear interactions
        for (int i = 0; i < 300; i++) pulse(8'hEE, 2'd0);
        chk("t5_sat", dc[0], 255);
        clr_ovf = 1'b1; cnt_in = 8'hEF; trig[0] = 1'b1;
        step();
        trig[0] = 1'b0;
        chk("t5_clr_drop_ovf", ovf[0], 1);
        chk("t5_clr_drop_cnt", dc[0], 1);
        step();
        clr_ovf = 1'b0;
        chk("t5_clr_ovf", ovf[0], 0);
        chk("t5_clr_cnt", dc[0], 0);
        rst = 1'b1; step(); rst = 1'b0; step();

        // 6: level trigger with free-flowing consumer
        rdy[1] = 1'b1; trig[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cnt_in = 8'(8'h40 + i); cc_in = 2'(i);
            step();
            chk("t6_level_le1", lvl[1] <= 1, 1);
        end
        trig[1] = 1'b0;
        repeat (3) step();
        chk("t6_pops", pops1, 6);
        chk("t6_nodrop", dc[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
